// File: rtl/lcd_id_reader_pkg.sv
// lcd_id_pkg: shared definitions for the LCD panel ID reader.
//   - panel ID codes as read from the {M2,M1,M0} straps
//   - strap bit positions on the 24-bit RGB pad bus
//   - reader state enum
//   - code_supported(): true for the codes downstream logic knows about
package lcd_id_pkg;

  localparam logic [2:0] ID_4342 = 3'd0;
  localparam logic [2:0] ID_7084 = 3'd1;
  localparam logic [2:0] ID_7016 = 3'd2;
  localparam logic [2:0] ID_1018 = 3'd5;

  localparam int M2_BIT = 7;
  localparam int M1_BIT = 15;
  localparam int M0_BIT = 23;

  typedef enum logic [1:0] {
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  function automatic logic code_supported(input logic [2:0] code);
    return (code == ID_4342) || (code == ID_7084) ||
           (code == ID_7016) || (code == ID_1018);
  endfunction

endpackage

// File: rtl/lcd_id_reader_sync_2ff.sv
// sync_2ff: plain two-flop synchronizer, reset to 0.
//   clk, rst_n : clock, async active-low reset
//   d [W]      : asynchronous input
//   q [W]      : synchronized output (2 cycles latency)
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lcd_id_reader.sv
// lcd_id_reader: reads the panel resolution straps {M2,M1,M0} off the RGB
// bus after reset, debounces them, and publishes a 16-bit panel ID.
// The RGB pads stay released (lcd_rgb_oe=0) until the ID is final.
//
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   lcd_rgb_in  : RGB pad inputs; M2/M1/M0 on bits 7/15/23
//   rescan      : one-cycle re-read request (only honoured in DONE when
//                 LCD_ID_RESCAN_EN is defined, otherwise ignored)
//   lcd_rgb_oe  : 1 = LCD driver may drive the pads
//   id_lcd      : {13'd0, M2, M1, M0}
//   id_valid    : id_lcd is final
//   id_err      : no stable code within the sample budget
//   id_unsup    : accepted code is not 0/1/2/5
//
// Build option: define LCD_ID_RESCAN_EN to enable rescan.
module lcd_id_reader
  import lcd_id_pkg::*;
#(
  parameter int SETTLE_CYC = 1000,
  parameter int SAMPLE_GAP = 16,
  parameter int SAMPLE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] lcd_rgb_in,
  input  logic        rescan,
  output logic        lcd_rgb_oe,
  output logic [15:0] id_lcd,
  output logic        id_valid,
  output logic        id_err,
  output logic        id_unsup
);

  localparam int MAX_TRIES = 4 * SAMPLE_CNT;
  localparam int SET_W     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int GAP_W     = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
  localparam int MATCH_W   = $clog2(SAMPLE_CNT + 1);
  localparam int TRY_W     = $clog2(MAX_TRIES + 1);

  localparam logic [SET_W-1:0]   SET_LAST  = SET_W'(SETTLE_CYC - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(SAMPLE_GAP - 1);
  localparam logic [MATCH_W-1:0] MATCH_TGT = MATCH_W'(SAMPLE_CNT);
  localparam logic [TRY_W-1:0]   TRY_TGT   = TRY_W'(MAX_TRIES);

  state_t             state;
  logic [SET_W-1:0]   settle_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [MATCH_W-1:0] match_cnt;
  logic [TRY_W-1:0]   tries;
  logic [2:0]         ref_code;
  logic [2:0]         strap;
  logic               rescan_hit;
  logic               unused_ok;

  sync_2ff #(.W(3)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({lcd_rgb_in[M2_BIT], lcd_rgb_in[M1_BIT], lcd_rgb_in[M0_BIT]}),
    .q     (strap)
  );

`ifdef LCD_ID_RESCAN_EN
  assign rescan_hit = rescan;
`else
  assign rescan_hit = 1'b0;
`endif

  // Only three pad bits matter here; the rest belong to the LCD driver.
  assign unused_ok = ^{lcd_rgb_in, rescan};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SETTLE;
      settle_cnt <= '0;
      gap_cnt    <= '0;
      match_cnt  <= '0;
      tries      <= '0;
      ref_code   <= '0;
      lcd_rgb_oe <= 1'b0;
      id_lcd     <= '0;
      id_valid   <= 1'b0;
      id_err     <= 1'b0;
      id_unsup   <= 1'b0;
    end else begin
      case (state)
        SETTLE: begin
          if (settle_cnt == SET_LAST) begin
            state      <= SAMPLE;
            settle_cnt <= '0;
            gap_cnt    <= '0;
            match_cnt  <= '0;
            tries      <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        SAMPLE: begin
          // Accept/timeout is evaluated the cycle after the deciding tick,
          // so outputs land one edge after the last sample. ref_code always
          // holds the most recent sample, so it is the ID in both cases.
          if (match_cnt == MATCH_TGT || tries == TRY_TGT) begin
            state      <= DONE;
            id_lcd     <= {13'd0, ref_code};
            id_err     <= (match_cnt != MATCH_TGT);
            id_unsup   <= !code_supported(ref_code);
            id_valid   <= 1'b1;
            lcd_rgb_oe <= 1'b1;
            gap_cnt    <= '0;
            match_cnt  <= '0;
            tries      <= '0;
          end else if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            tries   <= tries + 1'b1;
            if (tries != '0 && strap == ref_code) begin
              match_cnt <= match_cnt + 1'b1;
            end else begin
              ref_code  <= strap;
              match_cnt <= MATCH_W'(1);
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        DONE: begin
          // id_lcd is deliberately kept until the next DONE.
          if (rescan_hit) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            id_valid   <= 1'b0;
            lcd_rgb_oe <= 1'b0;
            id_err     <= 1'b0;
            id_unsup   <= 1'b0;
          end
        end

        default: state <= SETTLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_id_reader.sv
module tb_lcd_id_reader;

  typedef struct {
    int          edge_n;
    logic [15:0] id;
    logic        err;
    logic        unsup;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] lcd_rgb_in = '0;
  logic        rescan = 1'b0;
  logic        lcd_rgb_oe;
  logic [15:0] id_lcd;
  logic        id_valid;
  logic        id_err;
  logic        id_unsup;

  int   edge_cnt;
  int   total = 0;
  int   bad = 0;
  int   oe_viol = 0;
  exp_t exp_q[$];

  lcd_id_reader #(.SETTLE_CYC(20), .SAMPLE_GAP(4), .SAMPLE_CNT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lcd_rgb_in (lcd_rgb_in),
    .rescan     (rescan),
    .lcd_rgb_oe (lcd_rgb_oe),
    .id_lcd     (id_lcd),
    .id_valid   (id_valid),
    .id_err     (id_err),
    .id_unsup   (id_unsup)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  // Drive straps {M2,M1,M0}; other pad bits carry junk to catch bad slicing.
  task automatic set_strap(input logic [2:0] s);
    logic [23:0] v;
    v = 24'($urandom);
    v[7]  = s[2];
    v[15] = s[1];
    v[23] = s[0];
    lcd_rgb_in = v;
  endtask

  // Reset is asserted between clock edges, so zeros must appear immediately.
  task automatic do_reset(input logic [2:0] s);
    @(negedge clk);
    #2 rst_n = 1'b0;
    set_strap(s);
    #1;
    check("reset_state", {id_lcd, 12'd0, id_valid, lcd_rgb_oe, id_err, id_unsup}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int max_cyc);
    int n;
    n = 0;
    while (!id_valid && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (!id_valid) begin
      total++;
      bad++;
      $display("FAIL %s: timeout, id_valid still 0 after %0d cycles", name, max_cyc);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_edge(input int e);
    while (edge_cnt < e) @(negedge clk);
  endtask

  task automatic push(input int e, input logic [15:0] id, input logic err, input logic unsup);
    exp_t x;
    x.edge_n = e; x.id = id; x.err = err; x.unsup = unsup;
    exp_q.push_back(x);
  endtask

  // Monitor: on each rising id_valid pop an expectation and compare.
  initial begin
    logic prev_valid;
    exp_t x;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (lcd_rgb_oe && !id_valid) oe_viol++;
      if (id_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: id_lcd=%0d at edge %0d, nothing expected", id_lcd, edge_cnt);
        end else begin
          x = exp_q.pop_front();
          check("valid_edge", edge_cnt, x.edge_n);
          check("id_lcd", {16'd0, id_lcd}, {16'd0, x.id});
          check("id_err", {31'd0, id_err}, {31'd0, x.err});
          check("id_unsup", {31'd0, id_unsup}, {31'd0, x.unsup});
          check("oe_with_valid", {31'd0, lcd_rgb_oe}, 32'd1);
        end
      end
      prev_valid = id_valid;
    end
  end

  initial begin
    // stable 001
    push(37, 16'd1, 1'b0, 1'b0);
    do_reset(3'b001);
    wait_valid("stable_001", 200);

    // stable 101
    push(37, 16'd5, 1'b0, 1'b0);
    do_reset(3'b101);
    wait_valid("stable_101", 200);

    // stable 011 -> unsupported
    push(37, 16'd3, 1'b0, 1'b1);
    do_reset(3'b011);
    wait_valid("stable_011", 200);

    // toggling 000/010 every sample -> timeout, last sample (16th) is 010
    push(85, 16'd2, 1'b1, 1'b0);
    do_reset(3'b000);
    for (int k = 1; k <= 16; k++) begin
      wait_edge(20 + 4 * k);
      set_strap((k % 2 == 1) ? 3'b010 : 3'b000);
    end
    wait_valid("toggle", 200);

    // two samples of 000, then 010 stable
    push(45, 16'd2, 1'b0, 1'b0);
    do_reset(3'b000);
    wait_edge(29);
    set_strap(3'b010);
    wait_valid("late_settle", 200);

    // rescan from DONE
    push(37, 16'd1, 1'b0, 1'b0);
    do_reset(3'b001);
    wait_valid("pre_rescan", 200);
    set_strap(3'b010);
    repeat (3) @(negedge clk);
`ifdef LCD_ID_RESCAN_EN
    push(edge_cnt + 1 + 37, 16'd2, 1'b0, 1'b0);
`endif
    rescan = 1'b1;
    @(negedge clk);
    rescan = 1'b0;
`ifdef LCD_ID_RESCAN_EN
    check("rescan_valid", {31'd0, id_valid}, 32'd0);
    check("rescan_oe", {31'd0, lcd_rgb_oe}, 32'd0);
    check("rescan_id_kept", {16'd0, id_lcd}, 32'd1);
    wait_valid("post_rescan", 200);
`else
    check("rescan_ignored_valid", {31'd0, id_valid}, 32'd1);
    check("rescan_ignored_oe", {31'd0, lcd_rgb_oe}, 32'd1);
    repeat (60) @(negedge clk);
    check("rescan_ignored_id", {16'd0, id_lcd}, 32'd1);
    check("rescan_ignored_valid_late", {31'd0, id_valid}, 32'd1);
`endif

    // reset mid-SAMPLE, full restart with new straps
    do_reset(3'b001);
    wait_edge(30);
    push(37, 16'd5, 1'b0, 1'b0);
    do_reset(3'b101);
    wait_valid("restart", 200);

    check("queue_drained", exp_q.size(), 32'd0);
    check("oe_before_valid", oe_viol, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
